// File: rtl/i2c_seq_pkg.sv
// Shared types and payload helpers for the I2C threshold DAC sequencer.
package i2c_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_GAP,
    ST_FIN
  } seq_state_e;

  localparam logic [7:0] DAC_CMD_BYTE = 8'b1100_0000;
  localparam int THR_W  = 12;
  localparam int SEL_W  = 3;
  localparam int LINE_W = 2;

  // Bytes 1-2 of the DAC write: command byte, then selector in the top bits of byte 2.
  function automatic logic [15:0] dac_cmd_word(input logic [SEL_W-1:0] sel);
    return {DAC_CMD_BYTE, sel, 5'b00000};
  endfunction

  function automatic logic [15:0] dac_val_word(input logic [THR_W-1:0] thr);
    return {thr, 4'b0000};
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/seq_delay_timer.sv
// Loadable down-counter; tc_o is high on the last cycle of a loaded interval of load_val_i cycles.
module seq_delay_timer #(
  parameter int W = 10
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == W'(1));

endmodule

// File: rtl/i2c_threshold_sequencer.sv
// Walks enabled threshold DAC channels, presenting each payload to the 4-byte I2C sender for a timed ENABLE burst.
// Optional THRESH_CHANGE_DETECT_EN: a masked threshold change acts like a START request.
module i2c_threshold_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int NCH          = 4,
  parameter int SETUP_CYCLES = 4,
  parameter int HOLD_CYCLES  = 1000,
  parameter int GAP_CYCLES   = 100
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    start_i,
  input  logic [NCH-1:0]          chan_mask_i,
  input  logic [NCH*THR_W-1:0]    thresholds_i,
  input  logic [NCH*SEL_W-1:0]    dac_sel_i,
  input  logic [NCH*LINE_W-1:0]   line_sel_i,
  output logic [LINE_W-1:0]       i2c_lines_o,
  output logic [15:0]             i2c_data12_o,
  output logic [15:0]             i2c_data34_o,
  output logic                    i2c_enable_o,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam int MAX_CYC = max3(SETUP_CYCLES, HOLD_CYCLES, GAP_CYCLES);
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int IDX_W   = (NCH > 1) ? $clog2(NCH) : 1;

  // Returns {found, index} of the lowest set mask bit strictly above lo.
  function automatic logic [IDX_W:0] find_next(input logic [NCH-1:0] mask, input int lo);
    logic [IDX_W:0] r;
    r = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask[i] && (i > lo)) r = {1'b1, IDX_W'(i)};
    end
    return r;
  endfunction

  seq_state_e                state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [NCH-1:0]            mask_q, mask_d;
  logic [NCH*THR_W-1:0]      thr_q, thr_d;
  logic [NCH*SEL_W-1:0]      sel_q, sel_d;
  logic [NCH*LINE_W-1:0]     line_q, line_d;
  logic                      pend_q, pend_d;
  logic [LINE_W-1:0]         lines_q, lines_d;
  logic [15:0]               d12_q, d12_d;
  logic [15:0]               d34_q, d34_d;
  logic                      en_q, busy_q, done_q;

  logic                      req;
  logic                      tmr_load;
  logic [CNT_W-1:0]          tmr_val;
  logic                      tmr_tc;
  logic [IDX_W:0]            first_hit, next_hit;
  logic [IDX_W-1:0]          pl_idx;
  logic [NCH*THR_W-1:0]      src_thr;
  logic [NCH*SEL_W-1:0]      src_sel;
  logic [NCH*LINE_W-1:0]     src_line;
  logic [LINE_W-1:0]         pl_lines;
  logic [15:0]               pl_d12, pl_d34;

`ifdef THRESH_CHANGE_DETECT_EN
  logic [NCH*THR_W-1:0]      thr_prev_q;
  logic                      thr_chg;

  always_comb begin
    thr_chg = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (chan_mask_i[k] &&
          (thresholds_i[k*THR_W +: THR_W] != thr_prev_q[k*THR_W +: THR_W])) thr_chg = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      thr_prev_q <= '0;
    end else if (req) begin
      thr_prev_q <= thresholds_i;
    end
  end

  assign req = start_i | thr_chg;
`else
  assign req = start_i;
`endif

  // From IDLE the payload comes straight from the ports, since the snapshot lands on the same edge.
  assign first_hit = find_next(chan_mask_i, -1);
  assign next_hit  = find_next(mask_q, int'(idx_q));
  assign pl_idx    = (state_q == ST_IDLE) ? first_hit[IDX_W-1:0] : next_hit[IDX_W-1:0];
  assign src_thr   = (state_q == ST_IDLE) ? thresholds_i : thr_q;
  assign src_sel   = (state_q == ST_IDLE) ? dac_sel_i    : sel_q;
  assign src_line  = (state_q == ST_IDLE) ? line_sel_i   : line_q;
  assign pl_lines  = src_line[pl_idx*LINE_W +: LINE_W];
  assign pl_d12    = dac_cmd_word(src_sel[pl_idx*SEL_W +: SEL_W]);
  assign pl_d34    = dac_val_word(src_thr[pl_idx*THR_W +: THR_W]);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    mask_d   = mask_q;
    thr_d    = thr_q;
    sel_d    = sel_q;
    line_d   = line_q;
    pend_d   = pend_q;
    lines_d  = lines_q;
    d12_d    = d12_q;
    d34_d    = d34_q;
    tmr_load = 1'b0;
    tmr_val  = CNT_W'(SETUP_CYCLES);

    case (state_q)
      ST_IDLE: begin
        if (req || pend_q) begin
          pend_d = 1'b0;
          mask_d = chan_mask_i;
          thr_d  = thresholds_i;
          sel_d  = dac_sel_i;
          line_d = line_sel_i;
          if (first_hit[IDX_W]) begin
            state_d  = ST_LOAD;
            idx_d    = pl_idx;
            lines_d  = pl_lines;
            d12_d    = pl_d12;
            d34_d    = pl_d34;
            tmr_load = 1'b1;
            tmr_val  = CNT_W'(SETUP_CYCLES);
          end else begin
            state_d = ST_FIN;
          end
        end
      end
      ST_LOAD: begin
        if (tmr_tc) begin
          state_d  = ST_SEND;
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(HOLD_CYCLES);
        end
      end
      ST_SEND: begin
        if (tmr_tc) begin
          state_d  = ST_GAP;
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(GAP_CYCLES);
        end
      end
      ST_GAP: begin
        if (tmr_tc) begin
          if (next_hit[IDX_W]) begin
            state_d  = ST_LOAD;
            idx_d    = pl_idx;
            lines_d  = pl_lines;
            d12_d    = pl_d12;
            d34_d    = pl_d34;
            tmr_load = 1'b1;
            tmr_val  = CNT_W'(SETUP_CYCLES);
          end else begin
            state_d = ST_FIN;
          end
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Any request outside IDLE (including the FIN cycle) is remembered once.
    if (req && (state_q != ST_IDLE)) pend_d = 1'b1;
  end

  seq_delay_timer #(
    .W(CNT_W)
  ) u_timer (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .tc_o       (tmr_tc)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      mask_q  <= '0;
      thr_q   <= '0;
      sel_q   <= '0;
      line_q  <= '0;
      pend_q  <= 1'b0;
      lines_q <= '0;
      d12_q   <= '0;
      d34_q   <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
      thr_q   <= thr_d;
      sel_q   <= sel_d;
      line_q  <= line_d;
      pend_q  <= pend_d;
      lines_q <= lines_d;
      d12_q   <= d12_d;
      d34_q   <= d34_d;
      en_q    <= (state_d == ST_SEND);
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= (state_q == ST_FIN);
    end
  end

  assign i2c_lines_o  = lines_q;
  assign i2c_data12_o = d12_q;
  assign i2c_data34_o = d34_q;
  assign i2c_enable_o = en_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_i2c_threshold_sequencer.sv
// Scoreboard bench for i2c_threshold_sequencer: expected bursts queued at stimulus, popped on ENABLE/DONE.
module tb_i2c_threshold_sequencer;

  localparam int NCH   = 4;
  localparam int SETUP = 4;
  localparam int HOLD  = 1000;
  localparam int GAP   = 100;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  mask  = '0;
  logic [47:0] thr   = '0;
  logic [11:0] sel   = '0;
  logic [7:0]  line  = '0;
  logic [1:0]  lines;
  logic [15:0] d12, d34;
  logic        en, busy, done;

  typedef struct packed {
    logic        is_done;
    logic [1:0]  lines;
    logic [15:0] d12;
    logic [15:0] d34;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  logic mon_en  = 1'b0;
  logic prev_en = 1'b0;
  logic lat_arm = 1'b0;
  int   lat_s   = 0;
  int   rise_c  = -1;
  int   fall_c  = -1;

  i2c_threshold_sequencer #(
    .NCH(NCH), .SETUP_CYCLES(SETUP), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .start_i      (start),
    .chan_mask_i  (mask),
    .thresholds_i (thr),
    .dac_sel_i    (sel),
    .line_sel_i   (line),
    .i2c_lines_o  (lines),
    .i2c_data12_o (d12),
    .i2c_data34_o (d34),
    .i2c_enable_o (en),
    .busy_o       (busy),
    .done_o       (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (en && !prev_en) begin
        if (sb.size() == 0) begin
          check("unexpected_enable", 1, 0);
        end else begin
          e = sb.pop_front();
          check("enable_vs_done_marker", e.is_done, 0);
          check("i2c_lines", lines, e.lines);
          check("i2c_data12", d12, e.d12);
          check("i2c_data34", d34, e.d34);
        end
        if (fall_c >= 0) check("enable_low_gap", cyc - fall_c, GAP + SETUP);
        if (lat_arm) begin
          check("start_to_enable", cyc - lat_s, SETUP);
          lat_arm = 1'b0;
        end
        rise_c = cyc;
      end
      if (!en && prev_en) begin
        check("enable_width", cyc - rise_c, HOLD);
        fall_c = cyc;
      end
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check("done_marker", e.is_done, 1);
        end
        check("busy_low_at_done", busy, 0);
        if (fall_c >= 0) check("last_fall_to_done", cyc - fall_c, GAP + 1);
        fall_c  = -1;
        lat_arm = 1'b0;
      end
      prev_en = en;
    end
  end

  task automatic set_ch(input int k, input logic [11:0] t, input logic [2:0] s, input logic [1:0] l);
    thr[k*12 +: 12] = t;
    sel[k*3 +: 3]   = s;
    line[k*2 +: 2]  = l;
  endtask

  task automatic push_seq();
    for (int k = 0; k < NCH; k++) begin
      if (mask[k]) sb.push_back({1'b0, line[k*2 +: 2], {8'hC0, sel[k*3 +: 3], 5'b00000},
                                 {thr[k*12 +: 12], 4'h0}});
    end
    sb.push_back({1'b1, 34'b0});
  endtask

  task automatic pulse_start(input logic arm);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (arm) begin
      lat_s   = cyc;
      lat_arm = 1'b1;
    end
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_within_budget", done, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic seen;
    int   n;

    idle(3);
    check("rst_lines", lines, 0);
    check("rst_data12", d12, 0);
    check("rst_data34", d34, 0);
    check("rst_enable", en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    idle(2);

    // single channel burst with known payload constants
    mask = 4'b0100;
    set_ch(2, 12'd200, 3'd3, 2'd2);
    push_seq();
    pulse_start(1'b1);
    wait_done(2000);
    check("t1_hold_lines", lines, 2);
    check("t1_hold_data12", d12, 16'hC060);
    check("t1_hold_data34", d34, 16'h0C80);
    idle(5);

    // three channels, ascending order
    mask = 4'b1011;
    set_ch(0, 12'h123, 3'd1, 2'd0);
    set_ch(1, 12'hABC, 3'd5, 2'd1);
    set_ch(3, 12'hFFF, 3'd7, 2'd3);
    push_seq();
    pulse_start(1'b1);
    wait_done(5000);
    idle(5);

    // empty mask: DONE two cycles after START, BUSY one cycle wide
    mask = 4'b0000;
    push_seq();
    pulse_start(1'b0);
    @(negedge clk);
    check("t3_busy_c1", busy, 1);
    check("t3_done_c1", done, 0);
    @(negedge clk);
    check("t3_busy_c2", busy, 0);
    check("t3_done_c2", done, 1);
    idle(5);
    check("t3_busy_after", busy, 0);

    // repeated START while busy coalesces into one resampled sequence
    mask = 4'b0011;
    set_ch(0, 12'd10, 3'd2, 2'd1);
    set_ch(1, 12'd20, 3'd4, 2'd3);
    push_seq();
    pulse_start(1'b1);
    idle(300);
    set_ch(0, 12'h555, 3'd6, 2'd2);
    set_ch(1, 12'h777, 3'd0, 2'd0);
    push_seq();
    pulse_start(1'b0);
    idle(50);
    pulse_start(1'b0);
    idle(1500);
    pulse_start(1'b0);
    wait_done(4000);
    wait_done(4000);
    idle(2500);
    check("t4_queue_drained", sb.size(), 0);
    check("t4_idle_busy", busy, 0);

    // reset in the middle of SEND
    mask = 4'b0001;
    set_ch(0, 12'h3A5, 3'd2, 2'd1);
    push_seq();
    pulse_start(1'b1);
    n = 0;
    while (!en && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t5_enable_seen", en, 1);
    idle(50);
    mon_en = 1'b0;
    sb.delete();
    rst_n = 1'b0;
    mask  = '0;
    thr   = '0;
    #1;
    check("t5_async_enable", en, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_lines", lines, 0);
    check("t5_rst_data12", d12, 0);
    check("t5_rst_data34", d34, 0);
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen = seen | done;
    end
    check("t5_no_done", seen, 0);
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    prev_en = 1'b0;
    fall_c  = -1;
    lat_arm = 1'b0;
    mon_en  = 1'b1;
    idle(3);
    check("t5_post_rst_done", done, 0);
    mask = 4'b0001;
    set_ch(0, 12'h3A5, 3'd2, 2'd1);
    push_seq();
    pulse_start(1'b1);
    wait_done(2000);
    idle(5);

    // threshold change without START
    mask = 4'b0010;
    set_ch(1, 12'h9AB, 3'd1, 2'd2);
`ifdef THRESH_CHANGE_DETECT_EN
    push_seq();
    wait_done(2000);
    idle(5);
    check("t6_queue_drained", sb.size(), 0);
`else
    seen = 1'b0;
    repeat (300) begin
      @(negedge clk);
      seen = seen | busy | en;
    end
    check("t6_no_activity", seen, 0);
    check("t6_queue_drained", sb.size(), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
